// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// master = core/memory environment side, slave = load_store_unit side.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time over a req/gnt/rvalid bus.
// Ports: clk, rst_n (async, active low), bus (load_store_unit_if.slave).
module load_store_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_R, RESP
  } state_t;

  state_t state_q, state_d;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-3:0] maddr_q;
  logic [DATA_WIDTH-1:0] mwdata_q;
  logic [3:0]            mbe_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [2:0] f3;
  logic [1:0] off;
  logic       accept;
  logic       illegal;
  logic       misal;
  logic       bad;

  assign f3     = bus.req_funct3;
  assign off    = bus.req_addr[1:0];
  assign accept = (state_q == IDLE) && bus.req_valid;

  // 011/11x are undefined; BU/HU have no store form.
  assign illegal = (f3 == 3'b011)
                || (f3[2:1] == 2'b11)
                || (bus.req_we && f3[2]);
  assign misal = ((f3[1:0] == 2'b01) && off[0])
              || ((f3[1:0] == 2'b10) && (off != 2'b00));
  assign bad = illegal || misal;

  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.req_wdata;
    unique case (1'b1)
      f3[1:0] == 2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{bus.req_wdata[7:0]}};
      end
      f3[1:0] == 2'b01: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  logic [7:0]            lb;
  logic [15:0]           lh;
  logic [DATA_WIDTH-1:0] ld;

  always_comb begin
    lb = bus.mem_rdata[7:0];
    unique case (off_q)
      2'd1:    lb = bus.mem_rdata[15:8];
      2'd2:    lb = bus.mem_rdata[23:16];
      2'd3:    lb = bus.mem_rdata[31:24];
      default: lb = bus.mem_rdata[7:0];
    endcase
    lh = off_q[1] ? bus.mem_rdata[31:16]
                  : bus.mem_rdata[15:0];
    // funct3[2] selects zero extension.
    unique case (1'b1)
      f3_q[1:0] == 2'b00:
        ld = {{24{lb[7] & ~f3_q[2]}}, lb};
      f3_q[1:0] == 2'b01:
        ld = {{16{lh[15] & ~f3_q[2]}}, lh};
      default:
        ld = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.req_valid)
          state_d = bad ? RESP : ISSUE;
      ISSUE:
        if (bus.mem_gnt)
          state_d = we_q ? RESP : WAIT_R;
      WAIT_R:
        if (bus.mem_rvalid)
          state_d = RESP;
      RESP:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  logic o_ready;
  logic o_rvalid;
  logic o_mreq;
  logic o_mwe;

  always_comb begin
    o_ready  = (state_q == IDLE);
    o_rvalid = (state_q == RESP);
    o_mreq   = (state_q == ISSUE);
    o_mwe    = o_mreq && we_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= 4'b0000;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          we_q     <= bus.req_we;
          f3_q     <= f3;
          off_q    <= off;
          maddr_q  <= bus.req_addr[ADDR_WIDTH-1:2];
          mwdata_q <= wdata_d;
          mbe_q    <= be_d;
          if (bad) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        (state_q == ISSUE)
          && bus.mem_gnt && we_q: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        (state_q == WAIT_R)
          && bus.mem_rvalid: begin
          rdata_q <= ld;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = o_ready;
  assign bus.resp_valid = o_rvalid;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_req    = o_mreq;
  assign bus.mem_we     = o_mwe;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.mem_be     = mbe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  load_store_unit_if #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32)
  ) bus ();

  load_store_unit #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send(
    input logic        we,
    input logic [2:0]  f3,
    input logic [9:0]  addr,
    input logic [31:0] wdata
  );
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  // Leaves the bench in cycle +1 of the accepted transaction.
  task automatic txn(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [9:0]  addr,
    input logic [31:0] wdata,
    input int          gnt_dly,
    input int          rv_dly,
    input logic [31:0] word,
    input logic [7:0]  x_maddr,
    input logic [3:0]  x_be,
    input logic [31:0] x_wdata,
    input logic [31:0] x_rdata,
    input logic        x_err
  );
    send(we, f3, addr, wdata);
    if (x_err) begin
      chk({tag, ".err_rv"}, 32'(bus.resp_valid), 1);
      chk({tag, ".err"}, 32'(bus.resp_err), 1);
      chk({tag, ".err_rd"}, bus.resp_rdata, 0);
      chk({tag, ".err_mreq"}, 32'(bus.mem_req), 0);
      @(negedge clk);
      chk({tag, ".err_mreq2"}, 32'(bus.mem_req), 0);
      chk({tag, ".err_rdy"}, 32'(bus.req_ready), 1);
      chk({tag, ".err_hold"}, 32'(bus.resp_err), 1);
      return;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      chk({tag, ".mreq"}, 32'(bus.mem_req), 1);
      chk({tag, ".mwe"}, 32'(bus.mem_we), 32'(we));
      chk({tag, ".maddr"}, 32'(bus.mem_addr), 32'(x_maddr));
      chk({tag, ".mbe"}, 32'(bus.mem_be), 32'(x_be));
      chk({tag, ".mwdata"}, bus.mem_wdata, x_wdata);
      chk({tag, ".rdy0"}, 32'(bus.req_ready), 0);
      chk({tag, ".rv0"}, 32'(bus.resp_valid), 0);
      if (k == gnt_dly) bus.mem_gnt = 1'b1;
      @(negedge clk);
    end
    bus.mem_gnt = 1'b0;
    if (!we) begin
      for (int k = 0; k <= rv_dly; k++) begin
        chk({tag, ".wait_mreq"}, 32'(bus.mem_req), 0);
        chk({tag, ".wait_rdy"}, 32'(bus.req_ready), 0);
        chk({tag, ".wait_rv"}, 32'(bus.resp_valid), 0);
        if (k == rv_dly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = word;
        end
        @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h5A5A_0F0F;
    end
    chk({tag, ".rv"}, 32'(bus.resp_valid), 1);
    chk({tag, ".rdata"}, bus.resp_rdata, x_rdata);
    chk({tag, ".err"}, 32'(bus.resp_err), 0);
    chk({tag, ".rdy_resp"}, 32'(bus.req_ready), 0);
    @(negedge clk);
    chk({tag, ".rv_end"}, 32'(bus.resp_valid), 0);
    chk({tag, ".rdy"}, 32'(bus.req_ready), 1);
    chk({tag, ".hold"}, bus.resp_rdata, x_rdata);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 1);
    chk("rst.rv", 32'(bus.resp_valid), 0);
    chk("rst.err", 32'(bus.resp_err), 0);
    chk("rst.mreq", 32'(bus.mem_req), 0);
    chk("rst.mwe", 32'(bus.mem_we), 0);
    chk("rst.rdata", bus.resp_rdata, 0);
    chk("rst.maddr", 32'(bus.mem_addr), 0);
    chk("rst.mwdata", bus.mem_wdata, 0);
    chk("rst.mbe", 32'(bus.mem_be), 0);
    rst_n = 1'b1;

    // rvalid while idle must be ignored
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("idle_rvalid.rv", 32'(bus.resp_valid), 0);
    chk("idle_rvalid.rdy", 32'(bus.req_ready), 1);

    txn("lw", 1'b0, 3'b010, 10'h008, 32'h0, 0, 0,
        32'hDEAD_BEEF, 8'h02, 4'b1111, 32'h0,
        32'hDEAD_BEEF, 1'b0);
    txn("lb", 1'b0, 3'b000, 10'h003, 32'h0, 0, 0,
        32'h8011_2233, 8'h00, 4'b1000, 32'h0,
        32'hFFFF_FF80, 1'b0);
    txn("lbu", 1'b0, 3'b100, 10'h003, 32'h0, 0, 0,
        32'h8011_2233, 8'h00, 4'b1000, 32'h0,
        32'h0000_0080, 1'b0);
    txn("sh", 1'b1, 3'b001, 10'h006, 32'h1234_ABCD, 0, 0,
        32'h0, 8'h01, 4'b1100, 32'hABCD_ABCD,
        32'h0, 1'b0);
    txn("lw_mis", 1'b0, 3'b010, 10'h005, 32'h0, 0, 0,
        32'h0, 8'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("lh_stall", 1'b0, 3'b001, 10'h00A, 32'h0, 5, 3,
        32'h8001_7FFF, 8'h02, 4'b1100, 32'h0,
        32'hFFFF_8001, 1'b0);
    txn("lhu", 1'b0, 3'b101, 10'h002, 32'h0, 0, 1,
        32'h9ABC_1234, 8'h00, 4'b1100, 32'h0,
        32'h0000_9ABC, 1'b0);
    txn("lb_pos", 1'b0, 3'b000, 10'h001, 32'h0, 1, 0,
        32'h0000_7F00, 8'h00, 4'b0010, 32'h0,
        32'h0000_007F, 1'b0);
    txn("sb", 1'b1, 3'b000, 10'h3FD, 32'h0000_00A5, 2, 0,
        32'h0, 8'hFF, 4'b0010, 32'hA5A5_A5A5,
        32'h0, 1'b0);
    txn("sw", 1'b1, 3'b010, 10'h010, 32'hCAFE_F00D, 0, 0,
        32'h0, 8'h04, 4'b1111, 32'hCAFE_F00D,
        32'h0, 1'b0);
    txn("f3_011", 1'b0, 3'b011, 10'h000, 32'h0, 0, 0,
        32'h0, 8'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("f3_110", 1'b0, 3'b110, 10'h000, 32'h0, 0, 0,
        32'h0, 8'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("st_bu", 1'b1, 3'b100, 10'h000, 32'h0, 0, 0,
        32'h0, 8'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("lh_mis", 1'b0, 3'b001, 10'h001, 32'h0, 0, 0,
        32'h0, 8'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("sw_mis", 1'b1, 3'b010, 10'h002, 32'h0, 0, 0,
        32'h0, 8'h0, 4'b0, 32'h0, 32'h0, 1'b1);
    txn("hu_ok", 1'b0, 3'b101, 10'h3FE, 32'h0, 0, 0,
        32'h8765_4321, 8'hFF, 4'b1100, 32'h0,
        32'h0000_8765, 1'b0);

    // reset while waiting for read data
    send(1'b0, 3'b010, 10'h00C, 32'h0);
    chk("rst_mid.mreq", 32'(bus.mem_req), 1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("rst_mid.wait_rdy", 32'(bus.req_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.mreq0", 32'(bus.mem_req), 0);
    chk("rst_mid.rdy1", 32'(bus.req_ready), 1);
    chk("rst_mid.rdata0", bus.resp_rdata, 0);
    chk("rst_mid.maddr0", 32'(bus.mem_addr), 0);
    chk("rst_mid.mbe0", 32'(bus.mem_be), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("late_rv.rv", 32'(bus.resp_valid), 0);
    @(negedge clk);
    chk("late_rv.rv2", 32'(bus.resp_valid), 0);
    chk("late_rv.rdata", bus.resp_rdata, 0);
    chk("late_rv.rdy", 32'(bus.req_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
